// File: rtl/writeback_queue_if.sv
// Producer, register-file write and operand-lookup signals of the writeback queue.
interface writeback_queue_if;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        WE;
  logic [4:0]  WrReg;
  logic [31:0] InData;
  logic        stall;
  logic        overflow;
  logic [4:0]  lkA;
  logic [4:0]  lkB;
  logic        hitA;
  logic        hitB;
  logic [31:0] fwdA;
  logic [31:0] fwdB;

  // Pipeline / producer side.
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, lkA, lkB,
    input  WE, WrReg, InData, stall, overflow, hitA, hitB, fwdA, fwdB
  );

  // Queue side.
  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, lkA, lkB,
    output WE, WrReg, InData, stall, overflow, hitA, hitB, fwdA, fwdB
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: merges mem and alu results into a single register-file write port,
// one write per cycle, with a bypass lookup over all not-yet-committed entries.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  writeback_queue_if.slave bus
);

  localparam int unsigned    PtrW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  typedef logic [PtrW-1:0] ptr_t;

  logic [4:0]      rdQ   [DEPTH];
  logic [31:0]     dataQ [DEPTH];
  ptr_t            headQ, headD, tailQ, tailD, tailNext, aluIdx;
  logic [CntW-1:0] countQ, countD, freeSlots;
  logic            overflowQ, overflowD;
  logic            pop, memPush, aluPush, memAcc, aluAcc;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic ptr_t incPtr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Next-state: pop head, then accept mem before alu into the space the pop leaves.
  always_comb begin
    pop       = (countQ != '0);
    memPush   = bus.mem_valid && (bus.mem_rd != '0);
    aluPush   = bus.alu_valid && (bus.alu_rd != '0);
    freeSlots = DepthC - countQ + CntW'(pop);
    memAcc    = memPush && (freeSlots != '0);
    // alu is the one dropped first when only one slot remains.
    aluAcc    = aluPush && (freeSlots > CntW'(memAcc));
    countD    = countQ - CntW'(pop) + CntW'(memAcc) + CntW'(aluAcc);
    headD     = pop ? incPtr(headQ) : headQ;
    tailNext  = incPtr(tailQ);
    aluIdx    = memAcc ? tailNext : tailQ;
    tailD     = tailQ;
    if (memAcc && aluAcc) begin
      tailD = incPtr(tailNext);
    end else if (memAcc || aluAcc) begin
      tailD = tailNext;
    end
    overflowD = overflowQ | (memPush & ~memAcc) | (aluPush & ~aluAcc);
  end

  // State registers and entry storage; reset discards every queued entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headQ     <= '0;
      tailQ     <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rdQ[i]   <= '0;
        dataQ[i] <= '0;
      end
    end else begin
      headQ     <= headD;
      tailQ     <= tailD;
      countQ    <= countD;
      overflowQ <= overflowD;
      if (memAcc) begin
        rdQ[tailQ]   <= bus.mem_rd;
        dataQ[tailQ] <= bus.mem_data;
      end
      if (aluAcc) begin
        rdQ[aluIdx]   <= bus.alu_rd;
        dataQ[aluIdx] <= bus.alu_data;
      end
    end
  end

  // Register-file write port and status flags from registered state only.
  always_comb begin
    bus.WE       = (countQ != '0);
    bus.WrReg    = bus.WE ? rdQ[headQ] : '0;
    bus.InData   = bus.WE ? dataQ[headQ] : '0;
    bus.stall    = (countQ >= DepthC - 1'b1);
    bus.overflow = overflowQ;
  end

  // Bypass lookup: walk oldest to youngest so the youngest match wins; head included.
  always_comb begin
    ptr_t p;
    bus.hitA = 1'b0;
    bus.hitB = 1'b0;
    bus.fwdA = '0;
    bus.fwdB = '0;
    p        = headQ;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < countQ) begin
        if ((bus.lkA != '0) && (rdQ[p] == bus.lkA)) begin
          bus.hitA = 1'b1;
          bus.fwdA = dataQ[p];
        end
        if ((bus.lkB != '0) && (rdQ[p] == bus.lkB)) begin
          bus.hitB = 1'b1;
          bus.fwdB = dataQ[p];
        end
      end
      p = incPtr(p);
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios then random traffic against a queue model.
module tb_writeback_queue;
  localparam int unsigned Depth = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  writeback_queue_if bus();

  writeback_queue #(.DEPTH(Depth)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   ovfM = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest queued entry with a matching nonzero register wins.
  task automatic lookModel(input logic [4:0] lk, output logic hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = '0;
    if (lk != 0) begin
      foreach (q[i]) begin
        if (q[i].rd == lk) begin
          hit = 1'b1;
          fwd = q[i].data;
        end
      end
    end
  endtask

  task automatic checkAll();
    logic        hA, hB;
    logic [31:0] fA, fB;
    bit          we;
    we = (q.size() != 0);
    lookModel(bus.lkA, hA, fA);
    lookModel(bus.lkB, hB, fB);
    chk("WE", bus.WE, we);
    chk("WrReg", bus.WrReg, we ? q[0].rd : 5'd0);
    chk("InData", bus.InData, we ? q[0].data : 32'd0);
    chk("stall", bus.stall, (q.size() >= Depth - 1) ? 1'b1 : 1'b0);
    chk("overflow", bus.overflow, ovfM);
    chk("hitA", bus.hitA, hA);
    chk("fwdA", bus.fwdA, fA);
    chk("hitB", bus.hitB, hB);
    chk("fwdB", bus.fwdB, fB);
  endtask

  // One edge of the queue: retire head, then mem, then alu, capped at Depth.
  task automatic modelStep();
    if (q.size() != 0) void'(q.pop_front());
    if (bus.mem_valid && bus.mem_rd != 0) begin
      if (q.size() < Depth) q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      else ovfM = 1'b1;
    end
    if (bus.alu_valid && bus.alu_rd != 0) begin
      if (q.size() < Depth) q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      else ovfM = 1'b1;
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] la, input logic [4:0] lb);
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lkA       = la;
    bus.lkB       = lb;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic settle();
    #1;
    checkAll();
  endtask

  task automatic advance();
    @(posedge clock);
    if (!reset) modelStep();
    #1;
  endtask

  task automatic resetModel();
    q.delete();
    ovfM = 1'b0;
  endtask

  initial begin
    idle();
    // Reset state.
    #2;
    checkAll();
    chk("rst_we", bus.WE, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single alu push: written next cycle, then queue empty.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0);
    settle();
    advance();
    idle();
    settle();
    chk("s1_we", bus.WE, 32'd1);
    chk("s1_wrreg", bus.WrReg, 32'd5);
    chk("s1_indata", bus.InData, 32'h1234);
    advance();
    settle();
    chk("s1_we_off", bus.WE, 32'd0);

    // Simultaneous producers: mem first, then alu.
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd0, 5'd0);
    settle();
    advance();
    idle();
    settle();
    chk("s2_first", bus.WrReg, 32'd3);
    advance();
    settle();
    chk("s2_second", bus.WrReg, 32'd4);
    chk("s2_second_data", bus.InData, 32'hBBBB);
    advance();

    // R0 writes are dropped.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
    settle();
    advance();
    idle();
    settle();
    chk("s3_we", bus.WE, 32'd0);
    chk("s3_ovf", bus.overflow, 32'd0);

    // Two R7 entries: lookup returns the younger one; lkB=0 never hits.
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd0, 5'd0);
    settle();
    advance();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    settle();
    chk("s4_hitA", bus.hitA, 32'd1);
    chk("s4_fwdA", bus.fwdA, 32'h22);
    chk("s4_hitB", bus.hitB, 32'd0);
    advance();
    advance();
    idle();
    settle();

    // Both producers every cycle, ignoring stall.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd1, $urandom, 1'b1, 5'd2, $urandom, 5'd1, 5'd2);
      settle();
      advance();
    end
    idle();
    settle();
    chk("s5_stall", bus.stall, 32'd1);
    chk("s5_ovf", bus.overflow, 32'd1);
    advance();
    settle();
    chk("s5_ovf_held", bus.overflow, 32'd1);

    // Reset with entries pending clears everything at once.
    reset = 1'b1;
    resetModel();
    settle();
    chk("s6_we_rst", bus.WE, 32'd0);
    advance();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    settle();
    advance();
    idle();
    settle();
    chk("s6_one_write", bus.WrReg, 32'd9);
    advance();
    settle();
    chk("s6_done", bus.WE, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        resetModel();
        settle();
        advance();
        reset = 1'b0;
      end else begin
        drive(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        settle();
        advance();
      end
    end
    idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are 2 to 8.
REQ-002 SHALL have port clock, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have ports mem_valid (input, 1), mem_rd (input, 5) and mem_data (input, 32), carrying the load/memory-stage result, which is the older producer.
REQ-005 SHALL have ports alu_valid (input, 1), alu_rd (input, 5) and alu_data (input, 32), carrying the ALU result, which is the younger producer.
REQ-006 SHALL have ports WE (output, 1), WrReg (output, 5) and InData (output, 32), which drive the register-file write port.
REQ-007 SHALL have port stall, output, 1 bit, which tells producers to hold.
REQ-008 SHALL have port overflow, output, 1 bit, a sticky error flag.
REQ-009 SHALL have ports lkA, lkB (inputs, 5 each), hitA, hitB (outputs, 1 each) and fwdA, fwdB (outputs, 32 each), forming the pending-write lookup for operand bypass.

Function
REQ-010 SHALL be a circular FIFO of DEPTH entries, each holding {rd[4:0], data[31:0]}, with head and tail pointers and a count of 0..DEPTH.
REQ-011 SHALL drive WE = (count != 0), with WrReg and InData taken combinationally from the head entry; WrReg and InData SHALL be 0 when count = 0.
REQ-012 SHALL pop the head on every rising edge where count != 0, giving one register-file write per cycle.
REQ-013 SHALL enqueue a valid producer only when its rd != 0; writes to R0 are dropped silently and never set overflow.
REQ-014 SHALL, when both producers enqueue on the same edge, write mem before alu, preserving program order.
REQ-015 SHALL compute next count = count - pop + pushes within a single edge; a push into an empty queue is visible on WE immediately after that edge (1-cycle latency).
REQ-016 SHALL assert stall = (count >= DEPTH-1), combinationally from the registered count.
REQ-017 SHALL, when the computed next count would exceed DEPTH, drop the excess pushes (alu first, then mem) and set overflow; overflow is cleared only by reset.
REQ-018 SHALL assert hitX when lkX != 0 and any occupied entry has rd == lkX; fwdX SHALL be the data of the youngest such entry, and 0 when there is no hit.
REQ-019 SHALL exclude from lookup any entries pushed on the current edge; lookup sees registered queue contents only.
REQ-020 SHALL include the head entry currently presented on WE in the lookup, since the register file has not yet committed it.
REQ-021 SHALL wrap head and tail pointers modulo DEPTH.

Reset
REQ-022 SHALL, while reset = 1, force count = 0, head = tail = 0, WE = 0, WrReg = 0, InData = 0, stall = 0, overflow = 0, hitA = hitB = 0 and fwdA = fwdB = 0, independent of clock.
REQ-023 SHALL discard all queued entries on reset assertion mid-operation; no partial write SHALL appear after reset deasserts.
REQ-024 SHALL accept pushes starting on the first rising edge after reset deasserts.

Verification
REQ-025 SHALL be covered by the scenario: single push alu_rd=5, data=0x1234 into an empty queue -> next cycle WE=1, WrReg=5, InData=0x1234; the following cycle WE=0.
REQ-026 SHALL be covered by the scenario: simultaneous mem(rd=3, 0xAAAA) and alu(rd=4, 0xBBBB) -> writes R3 then R4 on consecutive cycles.
REQ-027 SHALL be covered by the scenario: alu_rd=0 valid -> nothing queued, WE stays 0, overflow stays 0.
REQ-028 SHALL be covered by the scenario: DEPTH=4, both producers pushing every cycle while ignoring stall -> stall=1 once count >= 3, excess alu pushes dropped, overflow=1 and held.
REQ-029 SHALL be covered by the scenario: queue holding R7=0x11 (older) and R7=0x22 (younger), lkA=7 -> hitA=1, fwdA=0x22; lkB=0 -> hitB=0.
REQ-030 SHALL be covered by the scenario: reset asserted with 3 entries queued -> WE=0 immediately; after release, one push yields exactly one write.
